// File: rtl/hazard_pkg.sv
// Shared types and constants for the register-scoreboard hazard controller.
// Optional performance counters are enabled with the HAZARD_PERF_EN macro.
package hazard_pkg;

   localparam int NREG          = 32;            // architectural registers, reg 0 is zero
   localparam int AW            = $clog2(NREG);  // register index width
   localparam int CNT_W         = 32;            // perf counter width
   localparam int MAX_STALL_DEF = 15;            // default watchdog threshold

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      ERR   = 2'd2
   } state_t;

   // One-hot decode of a register index into an NREG-wide mask.
   function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] idx);
      logic [NREG-1:0] one_s;
      one_s  = {{(NREG-1){1'b0}}, 1'b1};
      onehot = one_s << idx;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard bus: ID/WB requests in, stall and status out.
// The perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_scoreboard_if;
   import hazard_pkg::*;

   logic            id_valid;
   logic [AW-1:0]   id_rs;
   logic [AW-1:0]   id_rt;
   logic            id_uses_rt;
   logic            id_reg_write;
   logic [AW-1:0]   id_rd;
   logic            wb_reg_write;
   logic [AW-1:0]   wb_rd;
   logic            stall;
   logic [NREG-1:0] busy_vec;
   logic            wdog_err;
`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles;
   logic [CNT_W-1:0] hazard_events;

   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_rd,
      output wb_reg_write, wb_rd,
      input  stall, busy_vec, wdog_err, stall_cycles, hazard_events
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_rd,
      input  wb_reg_write, wb_rd,
      output stall, busy_vec, wdog_err, stall_cycles, hazard_events
   );
`else
   modport master (
      output id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_rd,
      output wb_reg_write, wb_rd,
      input  stall, busy_vec, wdog_err
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_uses_rt, id_reg_write, id_rd,
      input  wb_reg_write, wb_rd,
      output stall, busy_vec, wdog_err
   );
`endif

endinterface

// File: rtl/hazard_scoreboard_bank.sv
// Pending-writer bit bank: one bit per register, set on issue, cleared on
// writeback, with a same-cycle writeback bypass on the three read ports.
module scoreboard_bank
   import hazard_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            set_en,
   input  logic [AW-1:0]   set_idx,
   input  logic            clr_en,
   input  logic [AW-1:0]   clr_idx,
   input  logic [AW-1:0]   rs_idx,
   input  logic [AW-1:0]   rt_idx,
   input  logic [AW-1:0]   rd_idx,
   output logic [NREG-1:0] busy_vec,
   output logic            rs_busy,
   output logic            rt_busy,
   output logic            rd_busy
);

   logic [NREG-1:0] busy_r;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] clr_mask_s;
   logic [NREG-1:0] eff_busy_s;
   logic [NREG-1:0] busy_nxt_s;

   // Decode masks, apply the writeback bypass and build the next bank value.
   always_comb begin
      set_mask_s = {NREG{1'b0}};
      clr_mask_s = {NREG{1'b0}};
      if (set_en) begin
         set_mask_s = onehot(set_idx);
      end else begin
         set_mask_s = {NREG{1'b0}};
      end
      if (clr_en) begin
         clr_mask_s = onehot(clr_idx);
      end else begin
         clr_mask_s = {NREG{1'b0}};
      end
      // Register file is write-before-read, so a writeback this cycle already
      // satisfies any reader of that register.
      eff_busy_s = busy_r & ~clr_mask_s;
      // Set is applied after clear: a new writer of the same rd stays pending.
      busy_nxt_s = eff_busy_s | set_mask_s;
      // Reg 0 is hard-wired zero and can never be pending.
      busy_nxt_s[0] = 1'b0;
   end

   // Read muxes for the two sources and the destination.
   always_comb begin
      rs_busy = eff_busy_s[rs_idx];
      rt_busy = eff_busy_s[rt_idx];
      rd_busy = eff_busy_s[rd_idx];
   end

   // Scoreboard bit register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_r <= {NREG{1'b0}};
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   assign busy_vec = busy_r;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-scoreboard hazard controller driving the ID-stage stall.
// Detects RAW (rs/rt) and WAW (rd) hazards against pending writers and runs a
// stall watchdog that latches a sticky error on a hung pipeline.
// Define HAZARD_PERF_EN to add saturating stall_cycles / hazard_events counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int MAX_STALL = MAX_STALL_DEF
)(
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  bus
);

   localparam int SCNT_W = $clog2(MAX_STALL + 1);

   state_t            state_r;
   state_t            state_nxt_s;
   logic [SCNT_W-1:0] scnt_r;
   logic [SCNT_W-1:0] scnt_nxt_s;
   logic              wdog_r;
   logic              wdog_nxt_s;
   logic              episode_s;
   logic              hazard_s;
   logic              stall_s;
   logic              issue_s;
   logic              rs_busy_s;
   logic              rt_busy_s;
   logic              rd_busy_s;

   scoreboard_bank u_bank (
      .clk      (clk),
      .rst      (rst),
      .set_en   (issue_s),
      .set_idx  (bus.id_rd),
      .clr_en   (bus.wb_reg_write),
      .clr_idx  (bus.wb_rd),
      .rs_idx   (bus.id_rs),
      .rt_idx   (bus.id_rt),
      .rd_idx   (bus.id_rd),
      .busy_vec (bus.busy_vec),
      .rs_busy  (rs_busy_s),
      .rt_busy  (rt_busy_s),
      .rd_busy  (rd_busy_s)
   );

   // Hazard detection, stall and issue qualification (same-cycle, no latency).
   always_comb begin
      hazard_s = bus.id_valid &
                 (rs_busy_s |
                  (bus.id_uses_rt & rt_busy_s) |
                  (bus.id_reg_write & rd_busy_s));
      stall_s  = hazard_s | (state_r == ERR);
      issue_s  = bus.id_valid & ~stall_s & bus.id_reg_write &
                 (bus.id_rd != {AW{1'b0}});
   end

   // Watchdog FSM next-state: counts consecutive stalled cycles.
   always_comb begin
      state_nxt_s = state_r;
      scnt_nxt_s  = scnt_r;
      wdog_nxt_s  = wdog_r;
      episode_s   = 1'b0;
      case (state_r)
         RUN: begin
            if (hazard_s) begin
               state_nxt_s = STALL;
               scnt_nxt_s  = SCNT_W'(1);
               episode_s   = 1'b1;
            end else begin
               state_nxt_s = RUN;
               scnt_nxt_s  = {SCNT_W{1'b0}};
            end
         end
         STALL: begin
            if (!hazard_s) begin
               state_nxt_s = RUN;
               scnt_nxt_s  = {SCNT_W{1'b0}};
            end else if (scnt_r == SCNT_W'(MAX_STALL - 1)) begin
               state_nxt_s = ERR;
               wdog_nxt_s  = 1'b1;
            end else begin
               scnt_nxt_s  = scnt_r + SCNT_W'(1);
            end
         end
         ERR: begin
            // Only reset leaves the error state.
            state_nxt_s = ERR;
            wdog_nxt_s  = 1'b1;
         end
         default: begin
            // An illegal encoding is treated as a hung pipeline.
            state_nxt_s = ERR;
            wdog_nxt_s  = 1'b1;
         end
      endcase
   end

   // Watchdog FSM state, stall counter and sticky error register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= RUN;
         scnt_r  <= {SCNT_W{1'b0}};
         wdog_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         scnt_r  <= scnt_nxt_s;
         wdog_r  <= wdog_nxt_s;
      end
   end

   assign bus.stall    = stall_s;
   assign bus.wdog_err = wdog_r;

`ifdef HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cycles_r;
   logic [CNT_W-1:0] hazard_events_r;

   // Saturating perf counters: stalled cycles and stall episodes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles_r  <= {CNT_W{1'b0}};
         hazard_events_r <= {CNT_W{1'b0}};
      end else begin
         if (stall_s && (stall_cycles_r != {CNT_W{1'b1}})) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
         end
         if (episode_s && (hazard_events_r != {CNT_W{1'b1}})) begin
            hazard_events_r <= hazard_events_r + CNT_W'(1);
         end
      end
   end

   assign bus.stall_cycles  = stall_cycles_r;
   assign bus.hazard_events = hazard_events_r;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard.
module tb_hazard_scoreboard;
   import hazard_pkg::*;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   hazard_scoreboard_if bus ();

   hazard_scoreboard #(.MAX_STALL(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic id_drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urt, input logic rw, input logic [4:0] rd);
      bus.id_valid     = v;
      bus.id_rs        = rs;
      bus.id_rt        = rt;
      bus.id_uses_rt   = urt;
      bus.id_reg_write = rw;
      bus.id_rd        = rd;
   endtask

   task automatic wb_drive(input logic w, input logic [4:0] rd);
      bus.wb_reg_write = w;
      bus.wb_rd        = rd;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      wb_drive(1'b0, 5'd0);
      tick();
      tick();
      chk("reset_busy", 64'(bus.busy_vec), 64'h0);
      chk("reset_stall", 64'(bus.stall), 64'h0);
      chk("reset_wdog", 64'(bus.wdog_err), 64'h0);
      rst = 1'b0;
      tick();

      // 1: issue rd=5, then RAW on rs=5, released by same-cycle writeback
      id_drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5);
      #1 chk("t1_issue_stall", 64'(bus.stall), 64'h0);
      tick();
      chk("t1_busy_set", 64'(bus.busy_vec), 64'h20);
      id_drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
      #1 chk("t1_raw_stall", 64'(bus.stall), 64'h1);
      tick();
      wb_drive(1'b1, 5'd5);
      #1 chk("t1_wb_bypass", 64'(bus.stall), 64'h0);
      tick();
      wb_drive(1'b0, 5'd0);
      id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      chk("t1_busy_clr", 64'(bus.busy_vec), 64'h0);
`ifdef HAZARD_PERF_EN
      chk("t1_stall_cycles", 64'(bus.stall_cycles), 64'd1);
      chk("t1_hazard_events", 64'(bus.hazard_events), 64'd1);
`endif

      // 2: rd=0 is never tracked
      id_drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0);
      tick();
      chk("t2_busy_r0", 64'(bus.busy_vec), 64'h0);
      id_drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      #1 chk("t2_rs0_stall", 64'(bus.stall), 64'h0);

      // 3: WAW on rd=7 resolved by same-cycle writeback; set wins over clear
      id_drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
      tick();
      chk("t3_busy7", 64'(bus.busy_vec), 64'h80);
      wb_drive(1'b1, 5'd7);
      #1 chk("t3_waw_bypass", 64'(bus.stall), 64'h0);
      tick();
      chk("t3_set_wins", 64'(bus.busy_vec), 64'h80);
      id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      tick();
      wb_drive(1'b0, 5'd0);
      chk("t3_busy_clr", 64'(bus.busy_vec), 64'h0);

      // 4: rt only matters when id_uses_rt is set
      id_drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd3);
      tick();
      chk("t4_busy3", 64'(bus.busy_vec), 64'h08);
      id_drive(1'b1, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0);
      #1 chk("t4_rt_unused", 64'(bus.stall), 64'h0);
      bus.id_uses_rt = 1'b1;
      #1 chk("t4_rt_used", 64'(bus.stall), 64'h1);
      tick();
      id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      tick();

      // 5: watchdog trips on the 15th edge of a held hazard
      id_drive(1'b1, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 14; i++) tick();
      chk("t5_wdog_edge14", 64'(bus.wdog_err), 64'h0);
      tick();
      chk("t5_wdog_edge15", 64'(bus.wdog_err), 64'h1);
      id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      #1 chk("t5_err_stall", 64'(bus.stall), 64'h1);
      wb_drive(1'b1, 5'd3);
      tick();
      wb_drive(1'b0, 5'd0);
      chk("t5_err_wb_clr", 64'(bus.busy_vec), 64'h0);
      chk("t5_err_sticky", 64'(bus.stall), 64'h1);

      // 6: asynchronous reset mid-stall with busy_vec = 0xA0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      id_drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd5);
      tick();
      id_drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd7);
      tick();
      chk("t6_busy_a0", 64'(bus.busy_vec), 64'hA0);
      id_drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 5'd0);
      tick();
      chk("t6_pre_rst_stall", 64'(bus.stall), 64'h1);
      #2 rst = 1'b1;
      #1 chk("t6_rst_busy", 64'(bus.busy_vec), 64'h0);
      chk("t6_rst_stall", 64'(bus.stall), 64'h0);
      chk("t6_rst_wdog", 64'(bus.wdog_err), 64'h0);
`ifdef HAZARD_PERF_EN
      chk("t6_rst_stall_cycles", 64'(bus.stall_cycles), 64'd0);
      chk("t6_rst_hazard_events", 64'(bus.hazard_events), 64'd0);
`endif
      id_drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0);
      tick();
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
